// File: rtl/counter_sched.sv
// Round-robin job scheduler driving one shared loadable up/down counter; a job takes len+3 cycles from IDLE sample to DONE.
// No backpressure: requests are sampled only in IDLE and the job in flight always runs to completion.
module counter_sched #(
    parameter int NREQ = 4,
    parameter int LENW = 16,
    localparam int IW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*32-1:0]   req_val,
    input  logic [NREQ-1:0]      req_mode,
    input  logic [NREQ*LENW-1:0] req_len,
    output logic [NREQ-1:0]      grant,
    output logic                 done,
    output logic [IW-1:0]        done_id,
    output logic [31:0]          result,
    input  logic [31:0]          cnt_q,
    output logic                 cnt_load,
    output logic                 cnt_mode,
    output logic [31:0]          cnt_data
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   idx;
    logic [31:0]     val;
    logic            mode;
    logic [LENW-1:0] rem;
    logic [31:0]     result_q;
    logic [IW-1:0]   done_id_q;

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic              found;
    logic [IW:0]       sum;
    logic [IW-1:0]     pick;
    logic [31:0]       sel_val;
    logic              sel_mode;
    logic [LENW-1:0]   sel_len;

    // Rotate requests so bit 0 is the requester at ptr; the first set bit wins.
    assign dbl = {req, req} >> ptr;
    assign rot = dbl[NREQ-1:0];

    always_comb begin
        found    = 1'b0;
        sum      = '0;
        pick     = '0;
        sel_val  = '0;
        sel_mode = 1'b0;
        sel_len  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                sum   = {1'b0, ptr} + (IW+1)'(k);
                if (sum >= (IW+1)'(NREQ))
                    sum = sum - (IW+1)'(NREQ);
                pick  = sum[IW-1:0];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (IW'(i) == pick) begin
                sel_val  = req_val[32*i +: 32];
                sel_mode = req_mode[i];
                sel_len  = req_len[LENW*i +: LENW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= '0;
            idx       <= '0;
            val       <= '0;
            mode      <= 1'b0;
            rem       <= '0;
            result_q  <= '0;
            done_id_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        idx   <= pick;
                        val   <= sel_val;
                        mode  <= sel_mode;
                        rem   <= sel_len;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    state <= (rem == '0) ? DONE : RUN;
                end
                RUN: begin
                    rem <= rem - 1'b1;
                    if (rem == LENW'(1))
                        state <= DONE;
                end
                DONE: begin
                    result_q  <= cnt_q;
                    done_id_q <= idx;
                    ptr       <= (idx == IW'(NREQ-1)) ? '0 : idx + 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode the registered state so reset clears them without a clock.
    assign grant    = (state != IDLE) ? (NREQ'(1) << idx) : '0;
    assign done     = (state == DONE);
    assign result   = done ? cnt_q : result_q;
    assign done_id  = done ? idx : done_id_q;
    assign cnt_load = (state != RUN);
    assign cnt_mode = (state != IDLE) ? mode : 1'b0;
    assign cnt_data = (state == LOAD || state == RUN) ? val : cnt_q;

endmodule

// File: tb/tb_counter_sched.sv
// Bench for counter_sched: directed vector table, reset-mid-job sequence and randomized jobs against a job-level model.
module tb_counter_sched;

    localparam int NREQ = 4;
    localparam int LENW = 16;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ*32-1:0]   req_val;
    logic [NREQ-1:0]      req_mode;
    logic [NREQ*LENW-1:0] req_len;
    logic [NREQ-1:0]      grant;
    logic                 done;
    logic [1:0]           done_id;
    logic [31:0]          result;
    logic [31:0]          cnt_q;
    logic                 cnt_load;
    logic                 cnt_mode;
    logic [31:0]          cnt_data;

    int n_cmp = 0;
    int n_fail = 0;
    int m_ptr = 0;
    logic [31:0] exp_cnt = 32'd0;

    counter_sched #(.NREQ(NREQ), .LENW(LENW)) dut (
        .clk(clk), .rst(rst), .req(req), .req_val(req_val), .req_mode(req_mode),
        .req_len(req_len), .grant(grant), .done(done), .done_id(done_id),
        .result(result), .cnt_q(cnt_q), .cnt_load(cnt_load), .cnt_mode(cnt_mode),
        .cnt_data(cnt_data)
    );

    // Shared counter: reset when rst is low, load, or step by one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          cnt_q <= 32'd0;
        else if (cnt_load) cnt_q <= cnt_data;
        else if (cnt_mode) cnt_q <= cnt_q + 32'd1;
        else               cnt_q <= cnt_q - 32'd1;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Entered in the IDLE cycle where requests are sampled; leaves in the next IDLE cycle.
    task automatic run_job(input int id, input logic [31:0] res, input int len, input bit scramble);
        chk("idle_grant", {28'd0, grant}, 32'd0);
        chk("idle_done", {31'd0, done}, 32'd0);
        chk("idle_hold", cnt_q, exp_cnt);
        tick();
        for (int k = 1; k <= len + 2; k++) begin
            chk("grant", {28'd0, grant}, 32'd1 << id);
            chk("done", {31'd0, done}, (k == len + 2) ? 32'd1 : 32'd0);
            if (k == len + 2) begin
                chk("result", result, res);
                chk("done_id", {30'd0, done_id}, id);
            end
            if (scramble && k >= 2 && k <= len + 1) begin
                req      = 4'($urandom);
                req_val  = {$urandom, $urandom, $urandom, $urandom};
                req_mode = 4'($urandom);
                req_len  = {$urandom, $urandom};
            end
            tick();
        end
        exp_cnt = res;
        m_ptr   = (id + 1) % NREQ;
        chk("result_held", result, res);
        chk("done_id_held", {30'd0, done_id}, id);
    endtask

    typedef struct {
        logic [3:0]  mask;
        logic [31:0] val;
        logic        mode;
        int          len;
        int          id;
        logic [31:0] res;
        bit          scr;
    } vec_t;

    vec_t tbl[12];

    logic [31:0] rv[NREQ];
    logic        rm[NREQ];
    int          rl[NREQ];

    initial begin
        tbl[0]  = '{4'b0001, 32'd10,         1'b1, 5, 0, 32'd15,         1'b0};
        tbl[1]  = '{4'b0100, 32'd2,          1'b0, 4, 2, 32'hFFFF_FFFE,  1'b0};
        tbl[2]  = '{4'b0010, 32'hFFFF_FFFF,  1'b1, 1, 1, 32'd0,          1'b0};
        tbl[3]  = '{4'b1000, 32'd1234,       1'b0, 0, 3, 32'd1234,       1'b0};
        tbl[4]  = '{4'b1111, 32'd7,          1'b1, 1, 0, 32'd8,          1'b0};
        tbl[5]  = '{4'b1111, 32'd7,          1'b1, 1, 1, 32'd8,          1'b0};
        tbl[6]  = '{4'b1111, 32'd7,          1'b1, 1, 2, 32'd8,          1'b0};
        tbl[7]  = '{4'b1111, 32'd7,          1'b1, 1, 3, 32'd8,          1'b0};
        tbl[8]  = '{4'b1111, 32'd7,          1'b1, 1, 0, 32'd8,          1'b0};
        tbl[9]  = '{4'b1010, 32'd100,        1'b0, 3, 1, 32'd97,         1'b0};
        tbl[10] = '{4'b1010, 32'd100,        1'b0, 3, 3, 32'd97,         1'b1};
        tbl[11] = '{4'b0011, 32'd0,          1'b0, 2, 0, 32'hFFFF_FFFE,  1'b1};

        rst = 1'b0; req = '0; req_val = '0; req_mode = '0; req_len = '0;
        #3;
        chk("rst_grant", {28'd0, grant}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_done_id", {30'd0, done_id}, 32'd0);
        chk("rst_cnt_load", {31'd0, cnt_load}, 32'd1);
        chk("rst_cnt_mode", {31'd0, cnt_mode}, 32'd0);
        tick();
        tick();
        rst = 1'b1;

        for (int t = 0; t < 12; t++) begin
            req      = tbl[t].mask;
            req_val  = {NREQ{tbl[t].val}};
            req_mode = {NREQ{tbl[t].mode}};
            req_len  = {NREQ{LENW'(tbl[t].len)}};
            run_job(tbl[t].id, tbl[t].res, tbl[t].len, tbl[t].scr);
        end

        // Reset in the middle of a RUN: no done pulse, then lowest index wins.
        req = 4'b0100; req_val = {NREQ{32'd500}}; req_mode = '1; req_len = {NREQ{16'd10}};
        tick(); tick(); tick(); tick();
        chk("pre_rst_grant", {28'd0, grant}, 32'd1 << m_ptr_winner(4'b0100));
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_grant", {28'd0, grant}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_result", result, exp_cnt_reset());
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_no_done", {31'd0, done}, 32'd0);
        end
        rst = 1'b1;
        m_ptr = 0; exp_cnt = 32'd0;
        req = 4'b1010; req_val = {NREQ{32'd40}}; req_mode = '0; req_len = {NREQ{16'd2}};
        run_job(1, 32'd38, 2, 1'b0);

        // Randomized jobs with occasional idle gaps.
        for (int j = 0; j < 40; j++) begin
            int gap;
            int w;
            logic [3:0] mask;
            logic [31:0] r;
            gap = $urandom_range(0, 3);
            if (j % 3 == 0) begin
                req = '0;
                for (int g = 0; g < gap; g++) begin
                    tick();
                    chk("gap_grant", {28'd0, grant}, 32'd0);
                    chk("gap_hold", cnt_q, exp_cnt);
                end
            end
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < NREQ; i++) begin
                rv[i] = (j % 5 == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3)) : $urandom;
                rm[i] = 1'($urandom);
                rl[i] = $urandom_range(0, 12);
                req_val[32*i +: 32]     = rv[i];
                req_mode[i]             = rm[i];
                req_len[LENW*i +: LENW] = LENW'(rl[i]);
            end
            req = mask;
            w = m_ptr_winner(mask);
            r = rm[w] ? rv[w] + 32'(rl[w]) : rv[w] - 32'(rl[w]);
            run_job(w, r, rl[w], j[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Round-robin choice: first requesting index at or after m_ptr, wrapping.
    function automatic int m_ptr_winner(input logic [3:0] mask);
        for (int k = 0; k < NREQ; k++)
            if (mask[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        return 0;
    endfunction

    function automatic logic [31:0] exp_cnt_reset();
        return 32'd0;
    endfunction

endmodule
